// File: rtl/upload_pkg.sv
// Shared types and constants for the FIFO upload sequencer.
// Build option: UPLOAD_HEADER_EN enables the leading header word.
package upload_pkg;

  localparam int DEF_DW    = 14;
  localparam int DEF_OW    = 16;
  localparam int DEF_CNT_W = 16;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam logic [1:0] BW_14 = 2'b00;
  localparam logic [1:0] BW_12 = 2'b01;
  localparam logic [1:0] BW_10 = 2'b10;
  localparam logic [1:0] BW_8  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_A,
    RD_B,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic vld;
    logic sel_b;
  } pipe_t;

endpackage

// File: rtl/sample_formatter.sv
// Right-justifies a raw sample to the selected bit width.
// Purely combinational; the caller registers the result.
module sample_formatter
  import upload_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int OW = DEF_OW
) (
  input  logic [1:0]    bw,
  input  logic [DW-1:0] sample,
  output logic [OW-1:0] word
);

  always_comb begin
    word = '0;
    unique case (bw)
      BW_14: word = OW'(sample);
      BW_12: word = OW'(sample >> 2);
      BW_10: word = OW'(sample >> 4);
      BW_8:  word = OW'(sample >> 6);
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/upload_sequencer.sv
// Interleaves FIFO A/B samples onto the host bus, A first per pair.
// Build option: UPLOAD_HEADER_EN emits one header word per upload.
module upload_sequencer #(
  parameter int DW    = upload_pkg::DEF_DW,
  parameter int OW    = upload_pkg::DEF_OW,
  parameter int CNT_W = upload_pkg::DEF_CNT_W
) (
  input  logic             rdclk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [1:0]       bw_bits,
  input  logic [DW-1:0]    fifo_dout_a,
  input  logic [DW-1:0]    fifo_dout_b,
  input  logic             fifo_empty_a,
  input  logic             fifo_empty_b,
  output logic             rden_a,
  output logic             rden_b,
  output logic [OW-1:0]    dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  import upload_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [1:0]       bw_q;
  pipe_t            p1;
  logic [DW-1:0]    smp;
  logic [OW-1:0]    fmt_word;

  // Read enables must drop in the very cycle abort rises.
  assign rden_a = (state == RD_A) && !fifo_empty_a && !abort;
  assign rden_b = (state == RD_B) && !fifo_empty_b && !abort;

  assign smp = p1.sel_b ? fifo_dout_b : fifo_dout_a;

  sample_formatter #(
    .DW(DW),
    .OW(OW)
  ) u_fmt (
    .bw    (bw_q),
    .sample(smp),
    .word  (fmt_word)
  );

  always_ff @(posedge rdclk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      bw_q       <= '0;
      p1         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      p1.vld     <= rden_a || rden_b;
      p1.sel_b   <= rden_b;
      dout_valid <= p1.vld;
      if (p1.vld)
        dout <= fmt_word;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            rem      <= num_samples;
            bw_q     <= bw_bits;
            busy     <= 1'b1;
            underrun <= 1'b0;
`ifdef UPLOAD_HEADER_EN
            state <= HDR;
`else
            state <= (num_samples == '0) ? DRAIN : RD_A;
`endif
          end
        end
`ifdef UPLOAD_HEADER_EN
        HDR: begin
          dout       <= OW'({HDR_MAGIC, 2'b00, bw_q, 4'h0});
          dout_valid <= 1'b1;
          state      <= (abort || rem == '0) ? DRAIN : RD_A;
        end
`endif
        RD_A: begin
          if (abort)
            state <= DRAIN;
          else if (fifo_empty_a)
            underrun <= 1'b1;
          else
            state <= RD_B;
        end
        RD_B: begin
          if (abort)
            state <= DRAIN;
          else if (fifo_empty_b)
            underrun <= 1'b1;
          else begin
            rem   <= rem - CNT_W'(1);
            state <= (rem == CNT_W'(1)) ? DRAIN : RD_A;
          end
        end
        DRAIN: state <= DONE;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
